// File: rtl/ex_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_seq_if
// Description : EX-stage divide sequencer bus (issue side and result side).
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_div_seq_if #(
    parameter int XLEN = 64
);
    logic [7:0]      div_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            ex_stall;
    logic            flush;
    logic            stallreq_div;
    logic [XLEN-1:0] div_result;
    logic            div_valid;

    modport master (
        output div_op, src1, src2, ex_stall, flush,
        input  stallreq_div, div_result, div_valid
    );

    modport slave (
        input  div_op, src1, src2, ex_stall, flush,
        output stallreq_div, div_result, div_valid
    );
endinterface
`default_nettype wire

// File: rtl/ex_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_seq
// Description : Radix-2 restoring divide sequencer for RV64M DIV/REM (+W).
//               Define DIV_EARLY_OUT_EN to finish trivial cases in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div_seq #(
    parameter int XLEN = 64
) (
    input  wire          clk,
    input  wire          rst,
    ex_div_seq_if.slave  bus
);
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]      r_state;
    logic [6:0]      r_count;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dsr;
    logic            r_is_rem;
    logic            r_word;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;
    logic            r_valid;

    // Operand decode and magnitude extraction for the start cycle
    logic            w_start;
    logic            w_is_word;
    logic            w_is_rem;
    logic            w_is_signed;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_ma;
    logic [XLEN-1:0] w_mb;
    logic            w_b_zero;

    assign w_start     = (bus.div_op != 8'd0);
    assign w_is_word   = |bus.div_op[7:4];
    assign w_is_rem    = bus.div_op[2] | bus.div_op[3] | bus.div_op[6] | bus.div_op[7];
    assign w_is_signed = bus.div_op[0] | bus.div_op[2] | bus.div_op[4] | bus.div_op[6];
    assign w_a = w_is_word ? {{32{w_is_signed & bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
    assign w_b = w_is_word ? {{32{w_is_signed & bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
    assign w_sa     = w_is_signed & w_a[XLEN-1];
    assign w_sb     = w_is_signed & w_b[XLEN-1];
    assign w_ma     = w_sa ? (~w_a + 1'b1) : w_a;
    assign w_mb     = w_sb ? (~w_b + 1'b1) : w_b;
    assign w_b_zero = (w_b == '0);

    // One restoring step on remainder:quotient
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_r_next;
    logic [XLEN-1:0] w_q_next;
    logic [XLEN-1:0] w_fix_q;
    logic [XLEN-1:0] w_fix_r;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_final;

    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dsr});
    assign w_r_next = w_ge ? (w_shift[XLEN-1:0] - r_dsr) : w_shift[XLEN-1:0];
    assign w_q_next = {r_quo[XLEN-2:0], w_ge};
    assign w_fix_q  = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
    assign w_fix_r  = r_neg_r ? (~w_r_next + 1'b1) : w_r_next;
    assign w_sel    = r_is_rem ? w_fix_r : w_fix_q;
    assign w_final  = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

`ifdef DIV_EARLY_OUT_EN
    logic            w_ovf;
    logic            w_small;
    logic            w_early;
    logic [XLEN-1:0] w_eq;
    logic [XLEN-1:0] w_er;
    logic [XLEN-1:0] w_esel;
    logic [XLEN-1:0] w_eres;

    assign w_ovf   = w_is_signed & (w_b == '1) &
                     (w_is_word ? (w_a == 64'hFFFF_FFFF_8000_0000)
                                : (w_a == 64'h8000_0000_0000_0000));
    assign w_small = (w_ma < w_mb);
    assign w_early = w_b_zero | w_ovf | w_small;
    assign w_eq    = w_b_zero ? '1 : (w_ovf ? w_a : '0);
    assign w_er    = w_ovf ? '0 : w_a;
    assign w_esel  = w_is_rem ? w_er : w_eq;
    assign w_eres  = w_is_word ? {{32{w_esel[31]}}, w_esel[31:0]} : w_esel;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_count  <= 7'd0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else if (bus.flush) begin
            r_state <= c_idle;
            r_count <= 7'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_start) begin
                        r_rem    <= '0;
                        r_quo    <= w_is_word ? {w_ma[31:0], 32'd0} : w_ma;
                        r_dsr    <= w_mb;
                        r_is_rem <= w_is_rem;
                        r_word   <= w_is_word;
                        // A zero divisor keeps the all-ones quotient unsigned-looking
                        r_neg_q  <= (w_sa ^ w_sb) & ~w_b_zero;
                        r_neg_r  <= w_sa;
`ifdef DIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_state  <= c_done;
                            r_count  <= 7'd0;
                            r_result <= w_eres;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= c_busy;
                            r_count <= w_is_word ? 7'd32 : 7'd64;
                        end
`else
                        r_state <= c_busy;
                        r_count <= w_is_word ? 7'd32 : 7'd64;
`endif
                    end
                end
                c_busy: begin
                    r_rem   <= w_r_next;
                    r_quo   <= w_q_next;
                    r_count <= r_count - 7'd1;
                    if (r_count == 7'd1) begin
                        r_state  <= c_done;
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                    end
                end
                c_done: begin
                    if (!bus.ex_stall) begin
                        r_state <= c_idle;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stallreq_div = ~rst & (((r_state == c_idle) & w_start) | (r_state == c_busy));
    assign bus.div_result   = r_result;
    assign bus.div_valid    = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_ex_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_div_seq
// Description : Directed self-checking bench for ex_div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div_seq;
    localparam logic [7:0] c_div   = 8'h01;
    localparam logic [7:0] c_divu  = 8'h02;
    localparam logic [7:0] c_rem   = 8'h04;
    localparam logic [7:0] c_remu  = 8'h08;
    localparam logic [7:0] c_divw  = 8'h10;
    localparam logic [7:0] c_divuw = 8'h20;
    localparam logic [7:0] c_remw  = 8'h40;

`ifdef DIV_EARLY_OUT_EN
    localparam int c_lat_trivial = 1;
`else
    localparam int c_lat_trivial = 65;
`endif
`ifdef DIV_EARLY_OUT_EN
    localparam int c_lat_trivial_w = 1;
`else
    localparam int c_lat_trivial_w = 33;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_div_seq_if #(.XLEN(64)) bus ();

    ex_div_seq #(.XLEN(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues an op at the current cycle (C0) and waits for div_valid; leaves div_op asserted.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        int cyc;
        int stalls;
        bus.div_op = op;
        bus.src1   = a;
        bus.src2   = b;
        #1;
        chk({tag, "_c0_stall"}, 64'(bus.stallreq_div), 64'd1);
        cyc    = 0;
        stalls = 1;
        while (!bus.div_valid && cyc < 200) begin
            step();
            cyc++;
            if (!bus.div_valid && bus.stallreq_div) stalls++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_stalls"}, 64'(stalls), 64'(lat));
        chk({tag, "_result"}, bus.div_result, exp);
        chk({tag, "_done_stall"}, 64'(bus.stallreq_div), 64'd0);
    endtask

    task automatic retire(input string tag);
        bus.div_op = 8'd0;
        step();
        chk({tag, "_idle_valid"}, 64'(bus.div_valid), 64'd0);
        chk({tag, "_idle_stall"}, 64'(bus.stallreq_div), 64'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.div_op   = c_div;
        bus.src1     = 64'd5;
        bus.src2     = 64'd3;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        step();
        step();
        chk("rst_stall", 64'(bus.stallreq_div), 64'd0);
        chk("rst_valid", 64'(bus.div_valid), 64'd0);
        chk("rst_result", bus.div_result, 64'd0);
        bus.div_op = 8'd0;
        rst = 1'b0;
        step();
        chk("post_rst_stall", 64'(bus.stallreq_div), 64'd0);

        run_op("divu_100_7", c_divu, 64'd100, 64'd7, 64'd14, 65);
        retire("divu_100_7");
        run_op("remu_100_7", c_remu, 64'd100, 64'd7, 64'd2, 65);
        retire("remu_100_7");
        run_op("div_m7_2", c_div, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        retire("div_m7_2");
        run_op("rem_m7_2", c_rem, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        retire("rem_m7_2");
        run_op("divw_ovf", c_divw, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, c_lat_trivial_w);
        retire("divw_ovf");
        run_op("remw_ovf", c_remw, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'd0, c_lat_trivial_w);
        retire("remw_ovf");
        run_op("divuw_sext", c_divuw, 64'h1234_5678_FFFF_FFFE, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFE, 33);
        retire("divuw_sext");
        run_op("divu_by0", c_divu, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, c_lat_trivial);
        retire("divu_by0");
        run_op("remu_by0", c_remu, 64'h1234, 64'd0, 64'h1234, c_lat_trivial);
        retire("remu_by0");
        run_op("div_neg_by0", c_div, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, c_lat_trivial);
        retire("div_neg_by0");
        run_op("rem_neg_by0", c_rem, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,
               64'hFFFF_FFFF_FFFF_FFF9, c_lat_trivial);
        retire("rem_neg_by0");

        // Flush at C10: no result, then a fresh divide in the next cycle
        bus.div_op = c_div;
        bus.src1   = 64'd1000;
        bus.src2   = 64'd9;
        repeat (10) begin
            step();
            chk("flush_pre_valid", 64'(bus.div_valid), 64'd0);
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_c11_valid", 64'(bus.div_valid), 64'd0);
        run_op("div_after_flush", c_div, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFF2, 65);
        retire("div_after_flush");

        // DONE held by ex_stall
        bus.ex_stall = 1'b1;
        run_op("hold", c_divu, 64'd100, 64'd7, 64'd14, 65);
        repeat (3) begin
            step();
            chk("hold_valid", 64'(bus.div_valid), 64'd1);
            chk("hold_result", bus.div_result, 64'd14);
            chk("hold_stall", 64'(bus.stallreq_div), 64'd0);
        end
        bus.ex_stall = 1'b0;
        retire("hold");

        // Reset mid-BUSY
        bus.div_op = c_divu;
        bus.src1   = 64'd100;
        bus.src2   = 64'd7;
        repeat (5) step();
        chk("mid_busy_stall", 64'(bus.stallreq_div), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 64'(bus.div_valid), 64'd0);
        chk("mid_rst_stall", 64'(bus.stallreq_div), 64'd0);
        rst        = 1'b0;
        bus.div_op = 8'd0;
        step();
        chk("post_mid_rst_stall", 64'(bus.stallreq_div), 64'd0);
        chk("post_mid_rst_valid", 64'(bus.div_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
